cic_decimator: RTL and testbench

Multi-channel, runtime-configurable CIC decimator for the MSO analogue acquisition path. It replaces the fixed single-channel decimator between the ADC capture front end and the sample buffer. It adds:
- a valid-qualified input stream;
- a power-of-two decimation ratio selected at run time;
- rounded, saturated rescaling to the output width;
- flush on ratio change and a saturation flag.

---
 rtl/mso_dsp_pkg.sv | 27 ++
 rtl/cic_channel.sv | 66 ++++++
 rtl/cic_decimator.sv | 66 ++++++
 tb/tb_cic_decimator.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mso_dsp_pkg.sv
// mso_dsp_pkg: shared sizing and rescaling helpers for the MSO acquisition DSP blocks.
package mso_dsp_pkg;

   localparam int WIDE = 64;
   typedef logic signed [WIDE-1:0] wide_t;

   function automatic int clog2(input int v);
      int r = 0;
      for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

   function automatic int cic_acc_width(input int x_width, input int stages, input int max_rate_log2);
      return x_width + stages * max_rate_log2;
   endfunction

   // Positive sh shifts left; negative sh shifts right rounding half-up.
   function automatic wide_t round_shift(input wide_t v, input int sh);
      return sh >= 0 ? v <<< sh : (v + (wide_t'(1) <<< (-sh - 1))) >>> (-sh);
   endfunction

   function automatic wide_t saturate(input wide_t v, input int w);
      wide_t hi = (wide_t'(1) <<< (w - 1)) - 1;
      return v > hi ? hi : v < -hi - 1 ? -hi - 1 : v;
   endfunction

endpackage

// File: rtl/cic_channel.sv
// cic_channel: one channel's integrator chain, comb chain and rounded/saturated rescaler.
module cic_channel import mso_dsp_pkg::*; #(
   parameter int X_WIDTH       = 8,
   parameter int Y_WIDTH       = 12,
   parameter int STAGES        = 3,
   parameter int MAX_RATE_LOG2 = 4
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    flush,
   input  logic                                    accept,
   input  logic [STAGES-1:0]                       ie,
   input  logic [STAGES:0]                         ce,
   input  logic [clog2(MAX_RATE_LOG2 + 1)-1:0]     rate,
   input  logic signed [X_WIDTH-1:0]               x,
   output logic signed [Y_WIDTH-1:0]               y,
   output logic                                    sat
);
   localparam int AW = cic_acc_width(X_WIDTH, STAGES, MAX_RATE_LOG2);
   typedef logic signed [AW-1:0] acc_t;

   acc_t  xr;
   int    net;
   wide_t scaled;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      acc_t integ, dly, comb, iin, cin;
      if (k == 0) begin : g_first
         assign iin = xr;
         assign cin = g_stage[STAGES-1].integ;
      end else begin : g_next
         assign iin = g_stage[k-1].integ;
         assign cin = g_stage[k-1].comb;
      end
      always_ff @(posedge clk or posedge rst)
         if (rst || flush) begin
            integ <= '0;
            dly   <= '0;
            comb  <= '0;
         end else begin
            if (ie[k]) integ <= integ + iin;
            if (ce[k]) begin
               dly  <= cin;
               comb <= cin - dly;
            end
         end
   end

   // Net shift folds the width change and the R^N CIC gain into one step.
   assign net    = (Y_WIDTH - X_WIDTH) - STAGES * int'(rate);
   assign scaled = round_shift(wide_t'(g_stage[STAGES-1].comb), net);

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         xr  <= '0;
         y   <= '0;
         sat <= 1'b0;
      end else begin
         if (accept) xr <= acc_t'(x);
         if (ce[STAGES] && !flush) begin
            y   <= Y_WIDTH'(saturate(scaled, Y_WIDTH));
            sat <= saturate(scaled, Y_WIDTH) != scaled;
         end
      end

endmodule

// File: rtl/cic_decimator.sv
// cic_decimator: multi-channel runtime-ratio CIC decimator; owns valid tags, decimation
// counter, rate latch and flush control shared by all channels.
module cic_decimator import mso_dsp_pkg::*; #(
   parameter int CHANNELS      = 2,
   parameter int X_WIDTH       = 8,
   parameter int Y_WIDTH       = 12,
   parameter int STAGES        = 3,
   parameter int MAX_RATE_LOG2 = 4
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   x_valid,
   input  logic [CHANNELS*X_WIDTH-1:0]            x,
   input  logic [clog2(MAX_RATE_LOG2 + 1)-1:0]    rate_log2,
   output logic                                   y_valid,
   output logic [CHANNELS*Y_WIDTH-1:0]            y,
   output logic [CHANNELS-1:0]                    sat
);
   localparam int RW = clog2(MAX_RATE_LOG2 + 1);
   localparam int CW = MAX_RATE_LOG2 > 0 ? MAX_RATE_LOG2 : 1;

   logic [RW-1:0]   rate_c, rate_q;
   logic [STAGES:0] vt;
   logic [STAGES-1:0] ct;
   logic [STAGES:0] ce;
   logic [CW-1:0]   cnt;
   logic            flush, accept, dec;

   assign rate_c = rate_log2 > RW'(MAX_RATE_LOG2) ? RW'(MAX_RATE_LOG2) : rate_log2;
   assign flush  = rate_c != rate_q;
   assign accept = x_valid && !flush;
   // vt[0] tags the input register, vt[k+1] tags integrator k; ce[k] enables comb k, ce[STAGES] the output.
   assign dec    = vt[STAGES] && cnt == CW'((32'd1 << rate_q) - 32'd1);
   assign ce     = {ct, dec};

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rate_q  <= '0;
         vt      <= '0;
         ct      <= '0;
         cnt     <= '0;
         y_valid <= 1'b0;
      end else if (flush) begin
         rate_q  <= rate_c;
         vt      <= '0;
         ct      <= '0;
         cnt     <= '0;
         y_valid <= 1'b0;
      end else begin
         vt      <= {vt[STAGES-1:0], x_valid};
         ct      <= ce[STAGES-1:0];
         y_valid <= ce[STAGES];
         if (vt[STAGES]) cnt <= dec ? '0 : cnt + 1'b1;
      end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      cic_channel #(
         .X_WIDTH(X_WIDTH), .Y_WIDTH(Y_WIDTH), .STAGES(STAGES), .MAX_RATE_LOG2(MAX_RATE_LOG2)
      ) u_ch (
         .clk(clk), .rst(rst), .flush(flush), .accept(accept),
         .ie(vt[STAGES-1:0]), .ce(ce), .rate(rate_q),
         .x(x[c*X_WIDTH +: X_WIDTH]), .y(y[c*Y_WIDTH +: Y_WIDTH]), .sat(sat[c])
      );
   end

endmodule

// File: tb/tb_cic_decimator.sv
// tb_cic_decimator: directed stimulus with a scoreboard fed by a direct-form CIC impulse-response model.
module tb_cic_decimator;
   localparam int XW = 8, YW = 12, ST = 3, MAXL = 4, LAT = 2 * ST + 1;

   typedef struct {
      int due;
      int y0, y1, z0, z1;
      logic s0, s1, t0, t1;
   } exp_t;

   logic        clk = 1'b0, rst = 1'b1, x_valid = 1'b0;
   logic [15:0] x = '0;
   logic [2:0]  rate_log2 = '0;
   logic        y_valid, z_valid;
   logic [23:0] y;
   logic [7:0]  z;
   logic [1:0]  sat, zsat;

   int n_assert = 0, n_fail = 0, ncyc = 0, n_pulse = 0, base;
   int m_rate = 0, m_cnt = 0;
   int hc[$], hist0[$], hist1[$];
   exp_t q[$];
   exp_t e;

   always #5 clk = ~clk;
   always @(posedge clk) ncyc <= ncyc + 1;

   cic_decimator dut (.clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .rate_log2(rate_log2),
                      .y_valid(y_valid), .y(y), .sat(sat));
   cic_decimator #(.Y_WIDTH(4)) dut4 (.clk(clk), .rst(rst), .x_valid(x_valid), .x(x),
                      .rate_log2(rate_log2), .y_valid(z_valid), .y(z), .sat(zsat));

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   // Impulse response of STAGES cascaded length-R boxcars.
   function automatic void build(input int r);
      int n = 1 << r;
      int t[$];
      int acc;
      hc = {1};
      for (int s = 0; s < ST; s++) begin
         t = {};
         for (int i = 0; i < hc.size() + n - 1; i++) begin
            acc = 0;
            for (int j = 0; j < n; j++) if (i - j >= 0 && i - j < hc.size()) acc += hc[i - j];
            t.push_back(acc);
         end
         hc = t;
      end
   endfunction

   function automatic int scale(input longint v, input int r, input int yw, output logic s);
      int net = yw - XW - ST * r;
      longint t = net >= 0 ? v * (64'sd1 << net) : (v + (64'sd1 << (-net - 1))) >>> (-net);
      longint hi = (64'sd1 << (yw - 1)) - 1;
      s = t > hi || t < -hi - 1;
      return int'(t > hi ? hi : t < -hi - 1 ? -hi - 1 : t);
   endfunction

   function automatic void drop(input int lim);
      while (q.size() > 0 && q[q.size() - 1].due >= lim) q.delete(q.size() - 1);
   endfunction

   function automatic void model(input logic v, input int a, input int b, input int r);
      int rc = r > MAXL ? MAXL : r;
      int n;
      longint s0 = 0, s1 = 0;
      exp_t t;
      if (rc != m_rate) begin
         m_rate = rc;
         m_cnt = 0;
         hist0.delete();
         hist1.delete();
         build(rc);
         drop(ncyc + 1);
         return;
      end
      if (!v) return;
      hist0.push_back(a);
      hist1.push_back(b);
      if (m_cnt < (1 << m_rate) - 1) begin
         m_cnt++;
         return;
      end
      m_cnt = 0;
      n = hist0.size();
      for (int j = 0; j < hc.size() && j < n; j++) begin
         s0 += longint'(hc[j]) * hist0[n - 1 - j];
         s1 += longint'(hc[j]) * hist1[n - 1 - j];
      end
      t.due = ncyc + 1 + LAT;  // accepted on the next edge
      t.y0 = scale(s0, m_rate, YW, t.s0);
      t.y1 = scale(s1, m_rate, YW, t.s1);
      t.z0 = scale(s0, m_rate, 4, t.t0);
      t.z1 = scale(s1, m_rate, 4, t.t1);
      q.push_back(t);
   endfunction

   task automatic step(input logic v, input int a, input int b, input int r);
      @(negedge clk);
      x_valid = v;
      x = {b[7:0], a[7:0]};
      rate_log2 = 3'(r);
      model(v, a, b, r);
   endtask

   task automatic idle(input int n, input int r);
      for (int i = 0; i < n; i++) step(1'b0, 0, 0, r);
   endtask

   function automatic int rnd();
      return int'($urandom_range(255)) - 128;
   endfunction

   initial forever begin
      @(negedge clk);
      if (q.size() > 0 && q[0].due == ncyc) begin
         e = q.pop_front();
         chk("y_valid", y_valid, 1);
         chk("z_valid", z_valid, 1);
         chk("y0", $signed(y[11:0]), e.y0);
         chk("y1", $signed(y[23:12]), e.y1);
         chk("sat", sat, {e.s1, e.s0});
         chk("z0", $signed(z[3:0]), e.z0);
         chk("z1", $signed(z[7:4]), e.z1);
         chk("zsat", zsat, {e.t1, e.t0});
      end else chk("stale_valid", {y_valid, z_valid}, 0);
      if (y_valid) n_pulse++;
   end

   initial begin
      build(0);
      repeat (3) @(negedge clk);
      chk("rst_y", y, 0);
      chk("rst_vld", y_valid, 0);
      chk("rst_sat", sat, 0);
      rst = 1'b0;

      base = n_pulse;
      for (int i = 0; i < 20; i++) step(1'b1, 1, 0, 0);
      idle(10, 0);
      chk("r1_pulses", n_pulse - base, 20);

      step(1'b0, 0, 0, 2);
      base = n_pulse;
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 127, -128, 2);
         step(1'b0, 0, 0, 2);
      end
      idle(10, 2);
      chk("r4_pulses", n_pulse - base, 10);
      chk("r4_y0", $signed(y[11:0]), 2032);
      chk("r4_y1", $signed(y[23:12]), -2048);
      chk("r4_z", {zsat, z}, {2'b01, 4'sd7 == 4'sd7 ? 4'b1000 : 4'b0, 4'b0111});

      base = n_pulse;
      for (int i = 0; i < 2; i++) step(1'b1, rnd(), rnd(), 2);
      step(1'b1, 50, -50, 3);
      for (int i = 0; i < 8; i++) step(1'b1, rnd(), rnd(), 3);
      idle(12, 3);
      chk("chg_pulses", n_pulse - base, 1);

      step(1'b0, 0, 0, 7);
      base = n_pulse;
      for (int i = 0; i < 48; i++) step(1'b1, rnd(), rnd(), 7);
      idle(10, 7);
      chk("clamp_pulses", n_pulse - base, 3);

      for (int i = 0; i < 5; i++) step(1'b1, rnd(), rnd(), 7);
      @(posedge clk);
      #2 rst = 1'b1;
      x_valid = 1'b0;
      m_rate = 0;
      m_cnt = 0;
      hist0.delete();
      hist1.delete();
      build(0);
      drop(ncyc);
      #1;
      chk("arst_y", y, 0);
      chk("arst_vld", y_valid, 0);
      chk("arst_sat", sat, 0);
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 0, 0, 7);
      base = n_pulse;
      for (int i = 0; i < 32; i++) step(1'b1, rnd(), rnd(), 7);
      idle(12, 7);
      chk("arst_pulses", n_pulse - base, 2);
      chk("pending", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
